// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU responder.
// Opcodes, FSM states and opcode classification helpers.
package alu_pkg;

    localparam int DEF_XLEN = 32;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) ||
               (op == OP_SRA);
    endfunction

    function automatic logic is_legal_op(input logic [3:0] op);
        return op <= OP_SUB;
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One-bit shifter used by the iterative shift path.
// Non-shift opcodes pass the value through unchanged.
module alu_shift_step
    import alu_pkg::*;
#(
    parameter int XLEN = DEF_XLEN
) (
    input  logic [XLEN-1:0] value,
    input  logic [3:0]      op,
    output logic [XLEN-1:0] shifted
);

    // select fill bit and direction for a single-bit shift
    always_comb begin
        shifted = value;
        case (op)
            OP_SLL:  shifted = {value[XLEN-2:0], 1'b0};
            OP_SRL:  shifted = {1'b0, value[XLEN-1:1]};
            OP_SRA:  shifted = {value[XLEN-1], value[XLEN-1:1]};
            default: shifted = value;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU responder with request/response handshakes.
// Logic/arith ops take one cycle, shifts iterate a bit per cycle.
module alu_seq
    import alu_pkg::*;
#(
    parameter int XLEN    = DEF_XLEN,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [3:0]      req_op,
    input  logic [XLEN-1:0] req_data1,
    input  logic [XLEN-1:0] req_data2,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic            rsp_zero,
    output logic            rsp_err
);

    state_t              state;
    logic [3:0]          op_q;
    logic [XLEN-1:0]     shreg;
    logic [XLEN-1:0]     step_val;
    logic [XLEN-1:0]     alu_res;
    logic [SHAMT_W-1:0]  cnt;
    logic [SHAMT_W-1:0]  shamt;
    logic                dec_illegal;
    logic                dec_single;
    logic                dec_shift_z;
    logic                dec_shift_nz;

    assign shamt = req_data2[SHAMT_W-1:0];

    alu_shift_step #(
        .XLEN(XLEN)
    ) u_step (
        .value  (shreg),
        .op     (op_q),
        .shifted(step_val)
    );

    // single-cycle result and mutually exclusive op classes
    always_comb begin
        alu_res = '0;
        case (req_op)
            OP_AND:  alu_res = req_data1 & req_data2;
            OP_OR:   alu_res = req_data1 | req_data2;
            OP_ADD:  alu_res = req_data1 + req_data2;
            OP_SUB:  alu_res = req_data1 - req_data2;
            default: alu_res = '0;
        endcase
        dec_illegal  = !is_legal_op(req_op);
        dec_shift_z  = is_shift_op(req_op) &&
                       (shamt == '0);
        dec_shift_nz = is_shift_op(req_op) &&
                       (shamt != '0);
        dec_single   = is_legal_op(req_op) &&
                       !is_shift_op(req_op);
    end

    // control FSM with registered handshake and response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
            cnt        <= '0;
            shreg      <= '0;
            op_q       <= OP_AND;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q <= req_op;
                        unique case (1'b1)
                            dec_illegal: begin
                                rsp_result <= '0;
                                rsp_zero   <= 1'b1;
                                rsp_err    <= 1'b1;
                                rsp_valid  <= 1'b1;
                                req_ready  <= 1'b0;
                                state      <= DONE;
                            end
                            dec_shift_z: begin
                                rsp_result <= req_data1;
                                rsp_zero   <= (req_data1 == '0);
                                rsp_err    <= 1'b0;
                                rsp_valid  <= 1'b1;
                                req_ready  <= 1'b0;
                                state      <= DONE;
                            end
                            dec_shift_nz: begin
                                shreg     <= req_data1;
                                cnt       <= shamt;
                                req_ready <= 1'b0;
                                state     <= SHIFT;
                            end
                            dec_single: begin
                                rsp_result <= alu_res;
                                rsp_zero   <= (alu_res == '0);
                                rsp_err    <= 1'b0;
                                rsp_valid  <= 1'b1;
                                req_ready  <= 1'b0;
                                state      <= DONE;
                            end
                        endcase
                    end
                end
                SHIFT: begin
                    shreg <= step_val;
                    cnt   <= cnt - SHAMT_W'(1);
                    if (cnt == SHAMT_W'(1)) begin
                        rsp_result <= step_val;
                        rsp_zero   <= (step_val == '0);
                        rsp_err    <= 1'b0;
                        rsp_valid  <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq.
// Directed plan cases plus randomized ops against a reference model.
module tb_alu_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_data1;
    logic [31:0] req_data2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_err;

    int compared   = 0;
    int mismatched = 0;

    alu_seq dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_data1 (req_data1),
        .req_data2 (req_data2),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_result(rsp_result),
        .rsp_zero  (rsp_zero),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    // Reference: plain arithmetic, latency from the shift amount.
    function automatic void model(input logic [3:0] op,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] r,
                                  output logic e,
                                  output int lat);
        int sh;
        sh  = int'(b[4:0]);
        r   = 32'h0;
        e   = 1'b0;
        lat = 1;
        case (op)
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_ADD: r = a + b;
            OP_SUB: r = a - b;
            OP_SLL: r = a << sh;
            OP_SRL: r = a >> sh;
            OP_SRA: r = $unsigned($signed(a) >>> sh);
            default: e = 1'b1;
        endcase
        if (op == OP_SLL || op == OP_SRL || op == OP_SRA)
            lat = (sh == 0) ? 1 : sh + 1;
    endfunction

    // Drives one request from a negedge, measures latency, holds
    // the response for `hold` cycles, then completes the handshake.
    task automatic issue(input logic [3:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input int hold,
                         input logic early,
                         output logic [31:0] res,
                         output logic z,
                         output logic e,
                         output int lat,
                         output logic stable,
                         output logic pv,
                         output logic pr);
        req_op    = op;
        req_data1 = a;
        req_data2 = b;
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 4'($urandom);
        req_data1 = $urandom;
        req_data2 = $urandom;
        rsp_ready = early;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 200);
        if (!rsp_valid) begin
            compared++;
            mismatched++;
            $display("FAIL rsp_timeout got no valid want valid");
        end
        res    = rsp_result;
        z      = rsp_zero;
        e      = rsp_err;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!rsp_valid || req_ready || rsp_result !== res ||
                rsp_zero !== z || rsp_err !== e)
                stable = 1'b0;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        pv = rsp_valid;
        pr = req_ready;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 4'h0;
        req_data1 = 32'h0;
        req_data2 = 32'h0;
        rsp_ready = 1'b0;
        #1;
        compared++;
        if (req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_req_ready got %b want 1", req_ready);
        end
        compared++;
        if (rsp_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_rsp_valid got %b want 0", rsp_valid);
        end
        compared++;
        if (rsp_result !== 32'h0 || rsp_zero !== 1'b0 ||
            rsp_err !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_rsp got %h/%b/%b want 0/0/0",
                     rsp_result, rsp_zero, rsp_err);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_arith();
        logic [31:0] r;
        logic z, e, st, pv, pr;
        int lat;
        issue(OP_ADD, 32'hFFFFFFFF, 32'h1, 0, 1'b0,
              r, z, e, lat, st, pv, pr);
        compared++;
        if (r !== 32'h0 || z !== 1'b1 || e !== 1'b0) begin
            mismatched++;
            $display("FAIL add_wrap got %h/%b/%b want 0/1/0", r, z, e);
        end
        compared++;
        if (lat !== 1) begin
            mismatched++;
            $display("FAIL add_latency got %0d want 1", lat);
        end
        compared++;
        if (pv !== 1'b0 || pr !== 1'b1) begin
            mismatched++;
            $display("FAIL add_release got v%b r%b want v0 r1", pv, pr);
        end
        issue(OP_SUB, 32'h12345678, 32'h12345678, 0, 1'b0,
              r, z, e, lat, st, pv, pr);
        compared++;
        if (r !== 32'h0 || z !== 1'b1) begin
            mismatched++;
            $display("FAIL sub_equal got %h/%b want 0/1", r, z);
        end
        issue(OP_SUB, 32'h0, 32'h1, 0, 1'b0,
              r, z, e, lat, st, pv, pr);
        compared++;
        if (r !== 32'hFFFFFFFF || z !== 1'b0) begin
            mismatched++;
            $display("FAIL sub_under got %h/%b want ffffffff/0", r, z);
        end
    endtask

    task automatic test_shift();
        logic [31:0] r;
        logic z, e, st, pv, pr;
        int lat;
        issue(OP_SRA, 32'h80000000, 32'h4, 0, 1'b0,
              r, z, e, lat, st, pv, pr);
        compared++;
        if (r !== 32'hF8000000 || lat !== 5) begin
            mismatched++;
            $display("FAIL sra4 got %h lat %0d want f8000000 lat 5",
                     r, lat);
        end
        issue(OP_SRL, 32'h80000000, 32'h4, 0, 1'b0,
              r, z, e, lat, st, pv, pr);
        compared++;
        if (r !== 32'h08000000 || lat !== 5) begin
            mismatched++;
            $display("FAIL srl4 got %h lat %0d want 08000000 lat 5",
                     r, lat);
        end
        issue(OP_SLL, 32'h1, 32'd31, 0, 1'b0,
              r, z, e, lat, st, pv, pr);
        compared++;
        if (r !== 32'h80000000 || lat !== 32) begin
            mismatched++;
            $display("FAIL sll31 got %h lat %0d want 80000000 lat 32",
                     r, lat);
        end
        issue(OP_SLL, 32'h1, 32'h0, 0, 1'b0,
              r, z, e, lat, st, pv, pr);
        compared++;
        if (r !== 32'h1 || lat !== 1 || e !== 1'b0) begin
            mismatched++;
            $display("FAIL sll0 got %h lat %0d err %b want 1 lat 1 err 0",
                     r, lat, e);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] r;
        logic z, e, st, pv, pr;
        int lat;
        issue(OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 10, 1'b0,
              r, z, e, lat, st, pv, pr);
        compared++;
        if (r !== 32'hF000F000) begin
            mismatched++;
            $display("FAIL bp_result got %h want f000f000", r);
        end
        compared++;
        if (st !== 1'b1) begin
            mismatched++;
            $display("FAIL bp_stable got %b want 1", st);
        end
        compared++;
        if (pv !== 1'b0 || pr !== 1'b1) begin
            mismatched++;
            $display("FAIL bp_release got v%b r%b want v0 r1", pv, pr);
        end
        issue(4'b1111, 32'h12345678, 32'h9ABCDEF0, 0, 1'b0,
              r, z, e, lat, st, pv, pr);
        compared++;
        if (r !== 32'h0 || e !== 1'b1 || z !== 1'b1 || lat !== 1) begin
            mismatched++;
            $display("FAIL illegal got %h/%b/%b lat %0d want 0/1/1 lat 1",
                     r, z, e, lat);
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] r;
        logic z, e, st, pv, pr;
        int lat;
        int seen;
        req_op    = OP_SLL;
        req_data1 = 32'h1;
        req_data2 = 32'd20;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (6) @(negedge clk);
        compared++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_busy got r%b v%b want r0 v0",
                     req_ready, rsp_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        compared++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_async got r%b v%b want r1 v0",
                     req_ready, rsp_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        rsp_ready = 1'b0;
        compared++;
        if (seen !== 0) begin
            mismatched++;
            $display("FAIL mid_no_rsp got %0d responses want 0", seen);
        end
        issue(OP_OR, 32'h0F0F0000, 32'h0000F0F0, 0, 1'b0,
              r, z, e, lat, st, pv, pr);
        compared++;
        if (r !== 32'h0F0FF0F0 || z !== 1'b0 || lat !== 1) begin
            mismatched++;
            $display("FAIL post_rst_or got %h/%b lat %0d want 0f0ff0f0/0 lat 1",
                     r, z, lat);
        end
    endtask

    task automatic test_back_to_back();
        int vcount;
        int overlap;
        int bad;
        req_op    = OP_ADD;
        req_data1 = 32'd100;
        req_data2 = 32'd23;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        vcount  = 0;
        overlap = 0;
        bad     = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                vcount++;
                if (rsp_result !== 32'd123) bad++;
            end
            if (rsp_valid && req_ready) overlap++;
        end
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rsp_ready = 1'b0;
        compared++;
        if (vcount !== 10) begin
            mismatched++;
            $display("FAIL b2b_count got %0d want 10", vcount);
        end
        compared++;
        if (overlap !== 0 || bad !== 0) begin
            mismatched++;
            $display("FAIL b2b_data got overlap %0d bad %0d want 0 0",
                     overlap, bad);
        end
    endtask

    task automatic test_random();
        logic [31:0] r, a, b, mr;
        logic z, e, st, pv, pr, me, early;
        logic [3:0] op;
        int lat, mlat, hold;
        for (int n = 0; n < 60; n++) begin
            op = 4'($urandom_range(0, 8));
            if (op > 4'd6) op = 4'($urandom_range(7, 15));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = a;
            if ($urandom_range(0, 3) == 0) a = 32'h0;
            early = 1'($urandom_range(0, 1));
            hold  = early ? 0 : $urandom_range(0, 2);
            model(op, a, b, mr, me, mlat);
            issue(op, a, b, hold, early, r, z, e, lat, st, pv, pr);
            compared++;
            if (r !== mr || z !== (mr == 32'h0) || e !== me) begin
                mismatched++;
                $display("FAIL rnd%0d op %h got %h/%b/%b want %h/%b/%b",
                         n, op, r, z, e, mr, mr == 32'h0, me);
            end
            compared++;
            if (lat !== mlat || st !== 1'b1 || pv !== 1'b0 ||
                pr !== 1'b1) begin
                mismatched++;
                $display("FAIL rnd%0d_ctl got lat %0d st%b v%b r%b want lat %0d st1 v0 r1",
                         n, lat, st, pv, pr, mlat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_shift();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Multi-cycle ALU responder with valid/ready handshakes on both sides.
- Accepts one operation request: opcode plus two XLEN-bit operands.
  - Logic and arithmetic ops complete in one cycle.
  - Shift ops iterate one bit per cycle.
- Returns the result, a zero flag and an illegal-op flag on a response channel.
- Sits between the execute-stage issue logic of the multi-cycle rv32i core and its writeback. It reuses the single-cycle ALU opcode set and extends it with shifts.

Parameters:
- XLEN, 32, operand and result width.
- SHAMT_W, $clog2(XLEN), shift-amount width (taken from data2[SHAMT_W-1:0]).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_op  input  4  operation code (see package).
- req_data1  input  XLEN  operand A (shift source).
- req_data2  input  XLEN  operand B (shift amount in low SHAMT_W bits for shifts).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_result  output  XLEN  result.
- rsp_zero  output  1  rsp_result == 0.
- rsp_err  output  1  req_op was not a legal encoding.

Behaviour:
- Reset: async assert forces state IDLE; req_ready=1 after reset; rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_err=0, internal shift counter=0. Reset mid-shift abandons the operation with no response.
- States IDLE, SHIFT, DONE.
- IDLE:
  - req_ready=1; accept when req_valid && req_ready.
  - AND/OR/ADD/SUB: result registered → DONE; rsp_valid rises the cycle after accept (latency 1).
  - SLL/SRL/SRA with shamt≠0: load shift register = data1 and counter = shamt → SHIFT.
  - SLL/SRL/SRA with shamt=0: result=data1 → DONE (latency 1).
  - Illegal op: result=0, rsp_err=1 → DONE (latency 1).
- SHIFT:
  - req_ready=0.
  - Each cycle: shift by one bit (SLL fills 0 at LSB, SRL fills 0 at MSB, SRA replicates MSB); counter decrements.
  - When counter reaches 1, the final shift is performed and the state goes to DONE.
  - Total latency = shamt cycles + 1, maximum XLEN.
- DONE:
  - rsp_valid=1, req_ready=0.
  - rsp_result, rsp_zero and rsp_err stay stable until rsp_valid && rsp_ready.
  - Then → IDLE with rsp_valid=0 next cycle; no request accept in the same cycle.
  - Back-to-back throughput is therefore one op per 2 cycles minimum.
- Arithmetic:
  - ADD/SUB wrap modulo 2^XLEN; no carry/overflow output.
  - rsp_zero is computed from the final result for every op. For SUB this means data1==data2 ⇒ zero=1.
  - rsp_err op: rsp_zero=1 because result=0.
- Request inputs are sampled only at accept; later changes are ignored.
- rsp_ready is ignored outside DONE.

Decomposition:
- Package alu_pkg holds:
  - XLEN default.
  - 4-bit op constants: AND=4'b0000, OR=4'b0001, ADD=4'b0010, SLL=4'b0011, SRL=4'b0100, SRA=4'b0101, SUB=4'b0110.
  - State enum {IDLE, SHIFT, DONE}.
  - Function is_shift_op().
- One sub-module: alu_shift_step. It is a combinational one-bit shifter taking value and op and returning the shifted value; it is instantiated inside alu_seq.
- Single-cycle ops are computed inline.

Test Plan:
- ADD 0xFFFFFFFF + 0x00000001, rsp_ready=1 → rsp_valid 1 cycle after accept, result 0x00000000, zero=1, err=0.
- SUB 0x12345678 − 0x12345678 → result 0, zero=1. SUB 0x00000000 − 0x00000001 → 0xFFFFFFFF, zero=0.
- SRA 0x80000000 by data2=0x00000004 → rsp_valid exactly 5 cycles after accept, result 0xF8000000. SRL same operands → 0x08000000.
- SLL 0x00000001 by 31 → latency 32, result 0x80000000. SLL by 0 → latency 1, result 0x00000001.
- Backpressure: AND 0xF0F0F0F0 & 0xFF00FF00 with rsp_ready=0 for 10 cycles → rsp_valid held, result 0xF000F000 stable, req_ready=0. Then rsp_ready=1 → IDLE, req_ready=1 the following cycle. Illegal op 4'b1111 → result 0, err=1.
- Assert rst during SHIFT of SLL by 20 at cycle 7 → rsp_valid=0 and req_ready=1 immediately and asynchronously. No response is emitted for that op; the next OR 0x0F0F0000 | 0x0000F0F0 returns 0x0F0FF0F0.
